// File: rtl/mem_port_arbiter.sv
// Shared 16-bit memory port arbiter: atomic fetch pair,
// data priority with fetch anti-starvation, ack timeout.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        f_req,
  input  logic        f_flush,
  input  logic [15:0] f_addr,
  input  logic [15:0] f_addr2,
  output logic [15:0] f_opc,
  output logic [15:0] f_k16,
  output logic        hold,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, FLO, FHI, DATA
  } state_t;

  state_t        state, state_n;
  logic          fbuf_v;
  logic          flush_pend;
  logic [15:0]   addr2;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic        fpend, dpend, wait_d;
  logic        done, tmo, xfer_end;
  logic        flushing;
  logic [15:0] rdata;
  logic        grant_f, grant_d, next_fhi;

  assign hold = (f_req & ~fbuf_v) | (d_req & ~d_done);

  assign fpend    = f_req & ~fbuf_v & ~f_flush;
  assign dpend    = d_req & ~d_done;
  assign done     = m_req & m_ack;
  assign tmo      = m_req & ~m_ack & (tmo_cnt == TLIM);
  assign xfer_end = done | tmo;
  assign rdata    = tmo ? 16'h0000 : m_rdata;
  assign flushing = f_flush | flush_pend;
  // a re-presented d_req is invisible while d_done is high,
  // so give it one bubble rather than letting fetch sneak in
  assign wait_d   = d_done & d_req & (starve_cnt != SMAX);

  always_comb begin
    state_n  = state;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    next_fhi = 1'b0;
    unique case (state)
      IDLE: begin
        if (dpend && fpend) begin
          if (starve_cnt == SMAX) grant_f = 1'b1;
          else                    grant_d = 1'b1;
        end else if (dpend) begin
          grant_d = 1'b1;
        end else if (fpend && !wait_d) begin
          grant_f = 1'b1;
        end
        if (grant_f) state_n = FLO;
        if (grant_d) state_n = DATA;
      end
      FLO: begin
        if (tmo) begin
          state_n = IDLE;
        end else if (done) begin
          if (flushing) state_n = IDLE;
          else begin
            state_n  = FHI;
            next_fhi = 1'b1;
          end
        end
      end
      FHI:  if (xfer_end) state_n = IDLE;
      DATA: if (xfer_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state      <= IDLE;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 16'h0000;
      m_wdata    <= 16'h0000;
      addr2      <= 16'h0000;
      f_opc      <= 16'h0000;
      f_k16      <= 16'h0000;
      d_rdata    <= 16'h0000;
      d_done     <= 1'b0;
      bus_err    <= 1'b0;
      fbuf_v     <= 1'b0;
      flush_pend <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_n;
      bus_err <= tmo;
      d_done  <= (state == DATA) & xfer_end;

      if (grant_f | grant_d | next_fhi) m_req <= 1'b1;
      else if (xfer_end)                m_req <= 1'b0;

      if (grant_d) begin
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_we    <= d_we;
      end else if (grant_f) begin
        m_addr <= f_addr;
        addr2  <= f_addr2;
        m_we   <= 1'b0;
      end else if (next_fhi) begin
        m_addr <= addr2;
      end else if (xfer_end) begin
        m_we <= 1'b0;
      end

      if (!m_req || xfer_end) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + 1'b1;

      if (state == DATA && xfer_end && !m_we)
        d_rdata <= rdata;
      if (state == FLO && xfer_end && !flushing)
        f_opc <= rdata;
      if (state == FHI && xfer_end && !flushing)
        f_k16 <= rdata;

      if (f_flush)
        fbuf_v <= 1'b0;
      else if (state == FHI && done && !flush_pend)
        fbuf_v <= 1'b1;
      else if (fbuf_v && !hold)
        fbuf_v <= 1'b0;

      if (state_n == IDLE)
        flush_pend <= 1'b0;
      else if (f_flush && (state == FLO || state == FHI))
        flush_pend <= 1'b1;

      if (grant_f)
        starve_cnt <= '0;
      else if (grant_d && fpend && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small
// memory responder (read data = addr ^ 16'h5A5A).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        f_req, f_flush;
  logic [15:0] f_addr, f_addr2;
  logic [15:0] f_opc, f_k16;
  logic        hold;
  logic        d_req, d_we;
  logic [15:0] d_addr, d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        m_req, m_we;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        bus_err;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter dut (
    .clk(clk), .a_rst(a_rst),
    .f_req(f_req), .f_flush(f_flush),
    .f_addr(f_addr), .f_addr2(f_addr2),
    .f_opc(f_opc), .f_k16(f_k16), .hold(hold),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  bit          ack_en = 1'b0;
  int          ack_wait = 0;
  int          wcnt = 0;
  int          seen = 0;
  logic [15:0] log_addr[$];
  logic        log_we[$];

  always @(posedge clk)
    if (m_req && m_ack) begin
      log_addr.push_back(m_addr);
      log_we.push_back(m_we);
    end

  always @(negedge clk) begin
    if (log_addr.size() != seen) begin
      wcnt = 0;
      seen = log_addr.size();
    end
    if (m_req && ack_en) begin
      m_ack   = (wcnt >= ack_wait);
      m_rdata = m_addr ^ 16'h5A5A;
      wcnt++;
    end else begin
      m_ack   = 1'b0;
      m_rdata = 16'h0000;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    f_req = 0; f_flush = 0; f_addr = 0; f_addr2 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    #1;
    n_chk++;
    if ({m_req, m_we, d_done, bus_err, hold} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000",
        {m_req, m_we, d_done, bus_err, hold});
    end
    n_chk++;
    if ({f_opc, f_k16, d_rdata, m_addr, m_wdata} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
        {f_opc, f_k16, d_rdata, m_addr, m_wdata});
    end
    repeat (3) tick();
    a_rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int base, n;
    base = log_addr.size();
    ack_en = 1; ack_wait = 0;
    f_addr = 16'h0100; f_addr2 = 16'h0102; f_req = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!hold) break;
      n++;
    end
    n_chk++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL fetch_hold: got %0d want 2", n);
    end
    n_chk++;
    if ({f_opc, f_k16} !== 32'h5B5A_5B58) begin
      n_fail++;
      $display("FAIL fetch_data: got %h want 5b5a5b58",
        {f_opc, f_k16});
    end
    n_chk++;
    if (log_addr.size() != base + 2) begin
      n_fail++;
      $display("FAIL fetch_cnt: got %0d want 2",
        log_addr.size() - base);
    end else if ({log_addr[base], log_addr[base+1],
                  log_we[base], log_we[base+1]}
                 !== {16'h0100, 16'h0102, 2'b00}) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h %h want 0100 0102",
        log_addr[base], log_addr[base+1]);
    end
    f_req = 0;
    repeat (3) tick();
    n_chk++;
    if ({log_addr.size() == base + 2, hold, dut.fbuf_v}
        !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_consume: got n=%0d hold=%b v=%b",
        log_addr.size() - base, hold, dut.fbuf_v);
    end
  endtask

  task automatic test_contention();
    int base;
    base = log_addr.size();
    ack_wait = 0;
    f_addr = 16'h0300; f_addr2 = 16'h0302;
    d_addr = 16'h1000; d_we = 0;
    f_req = 1; d_req = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (log_addr.size() >= base + 6) break;
    end
    n_chk++;
    if (log_addr.size() < base + 6) begin
      n_fail++;
      $display("FAIL cont_cnt: got %0d want 6",
        log_addr.size() - base);
    end else if ({log_addr[base], log_addr[base+1],
                  log_addr[base+2], log_addr[base+3],
                  log_addr[base+4], log_addr[base+5]}
                 !== {16'h1000, 16'h1000, 16'h1000,
                      16'h1000, 16'h0300, 16'h0302}) begin
      n_fail++;
      $display("FAIL cont_order: got %h %h %h %h %h %h",
        log_addr[base], log_addr[base+1],
        log_addr[base+2], log_addr[base+3],
        log_addr[base+4], log_addr[base+5]);
    end
    n_chk++;
    if (dut.starve_cnt !== 0) begin
      n_fail++;
      $display("FAIL cont_starve: got %0d want 0",
        dut.starve_cnt);
    end
    d_req = 0; f_req = 0;
    repeat (6) tick();
  endtask

  task automatic test_wait_store();
    ack_wait = 3;
    d_addr = 16'h2000; d_wdata = 16'hBEEF;
    d_we = 1; d_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_req) break;
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({m_req, m_we, m_addr, m_wdata}
          !== {2'b11, 16'h2000, 16'hBEEF}) begin
        n_fail++;
        $display("FAIL store_stable%0d: got %b %b %h %h",
          k, m_req, m_we, m_addr, m_wdata);
      end
      tick();
    end
    n_chk++;
    if ({m_req, d_done, d_rdata} !== {2'b01, 16'h4A5A}) begin
      n_fail++;
      $display("FAIL store_done: got %b %b %h want 0 1 4a5a",
        m_req, d_done, d_rdata);
    end
    d_req = 0; d_we = 0;
    tick();
    n_chk++;
    if (d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL store_pulse: got %b want 0", d_done);
    end
    tick();
  endtask

  task automatic test_flush();
    int base;
    base = log_addr.size();
    ack_wait = 1;
    f_addr = 16'h0400; f_addr2 = 16'h0402; f_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (log_addr.size() >= base + 1) break;
    end
    f_flush = 1;
    f_addr = 16'h0500; f_addr2 = 16'h0502;
    tick();
    f_flush = 0;
    tick();
    n_chk++;
    if ({hold, dut.fbuf_v, m_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_drop: got hold=%b v=%b req=%b",
        hold, dut.fbuf_v, m_req);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!hold) break;
    end
    n_chk++;
    if ({f_opc, f_k16} !== 32'h5F5A_5F58) begin
      n_fail++;
      $display("FAIL flush_refetch: got %h want 5f5a5f58",
        {f_opc, f_k16});
    end
    n_chk++;
    if (log_addr.size() != base + 4) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d want 4",
        log_addr.size() - base);
    end else if ({log_addr[base], log_addr[base+1],
                  log_addr[base+2], log_addr[base+3]}
                 !== {16'h0400, 16'h0402,
                      16'h0500, 16'h0502}) begin
      n_fail++;
      $display("FAIL flush_addr: got %h %h %h %h",
        log_addr[base], log_addr[base+1],
        log_addr[base+2], log_addr[base+3]);
    end
    f_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int n;
    ack_en = 0;
    d_addr = 16'h3000; d_we = 0; d_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_req) break;
    end
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_req) break;
      n++;
      tick();
    end
    n_chk++;
    if (n !== 255) begin
      n_fail++;
      $display("FAIL tmo_len: got %0d want 255", n);
    end
    n_chk++;
    if ({bus_err, d_done, d_rdata} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL tmo_abort: got %b %b %h want 1 1 0000",
        bus_err, d_done, d_rdata);
    end
    d_req = 0;
    tick();
    n_chk++;
    if ({bus_err, m_req, hold, dut.state} !== 5'b0) begin
      n_fail++;
      $display("FAIL tmo_idle: got %b %b %b %0d want 0 0 0 0",
        bus_err, m_req, hold, dut.state);
    end
  endtask

  task automatic test_reset_mid();
    ack_en = 0;
    d_addr = 16'h4000; d_wdata = 16'h1234;
    d_we = 1; d_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_req) break;
    end
    repeat (2) tick();
    #2 a_rst = 1'b0;
    #1;
    n_chk++;
    if ({m_req, m_we, m_addr, m_wdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_mid_bus: got %b %b %h %h want 0",
        m_req, m_we, m_addr, m_wdata);
    end
    n_chk++;
    if ({f_opc, f_k16, bus_err, d_done} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_mid_out: got %h %h %b %b want 0",
        f_opc, f_k16, bus_err, d_done);
    end
    d_req = 0; d_we = 0;
    tick();
    a_rst = 1'b1;
    ack_en = 1; ack_wait = 0;
    d_addr = 16'h0010; d_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d_done) break;
    end
    n_chk++;
    if ({d_done, d_rdata} !== {1'b1, 16'h5A4A}) begin
      n_fail++;
      $display("FAIL rst_restart: got %b %h want 1 5a4a",
        d_done, d_rdata);
    end
    d_req = 0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_wait_store();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
